miner_nonce_ctrl: RTL and testbench
===================================

Name: miner_nonce_ctrl

Overview:
Parametrised control unit for the mining datapath. It sequences N external double-SHA256 hasher pairs (cores) that share one LOOP-folded cnt/feedback schedule. It splits the nonce space across the cores and checks each core's final hash against a runtime difficulty. Golden nonces go into a result FIFO with a valid/ready handshake, for the MIPI TX / UART path. Compared with the single-core fixed-difficulty controller, it adds multi-core support, runtime difficulty, job start/abort, end-of-range detection and result buffering.

Parameters:
NUM_CORES, 2, number of hasher cores; power of 2, 1..LOOP.
LOOP_LOG2, 5, SHA round folding; legal range 2..5; LOOP = 1<<LOOP_LOG2.
PIPE_PASSES, (1<<(7-LOOP_LOG2))+1, number of passes between issuing a nonce and its hash appearing at the check.
FIFO_DEPTH, 4, result FIFO entries; power of 2, ≥2.

Ports:
hash_clk  in  1  single clock
reset  in  1  synchronous, active-high
job_valid  in  1  new job offered
job_ready  out  1  job accepted when job_valid & job_ready
job_midstate  in  256  midstate for the job
job_data  in  96  tail of the block header (data_buf[95:0])
job_nonce_start  in  32  first nonce; low log2(NUM_CORES) bits are forced to 0
job_difficulty  in  7  number of leading zero bits required
core_state  out  256  rx_state for every core
core_data  out  96  shared header tail
core_nonce  out  NUM_CORES*32  nonce for core k in slice k
cnt  out  6  round counter, shared by all cores
feedback  out  1  shared feedback
core_hash_top  in  NUM_CORES*64  hash2[255:192] of each core
result_valid  out  1  FIFO not empty
result_ready  in  1  consumer pop
result_nonce  out  32  golden nonce at FIFO head
result_core  out  8  core index at FIFO head
busy  out  1  state is RUN or DRAIN
exhausted  out  1  nonce range done (sticky until the next job)
drop_cnt  out  8  saturating count of results lost to a full FIFO

Behaviour:
- Reset values:
  - State IDLE; cnt=0; feedback=0; all nonces, state and data = 0.
  - FIFO empty, so result_valid=0; busy=0; exhausted=0; drop_cnt=0; job_ready=1.
- States:
  - IDLE: no sequencing; cnt holds at 0.
  - LOAD: one cycle. Latch midstate, data and difficulty. Set base = start & ~(NUM_CORES-1), check_base = base, warm = PIPE_PASSES. Clear pending hits and exhausted. job_ready=0 during LOAD only. Next state is RUN.
  - RUN:
    - cnt_next = (cnt+1) & (LOOP-1).
    - feedback registers (cnt_next != 0); feedback_d1 is feedback delayed one cycle.
    - When cnt_next==0 (a pass boundary): core_nonce[k] <= base+k, then base += NUM_CORES.
    - If base+NUM_CORES carries out of 32 bits, that pass is the last one issued: go to DRAIN.
  - DRAIN: cnt keeps cycling; core_nonce is frozen. When the last issued nonce has been checked: exhausted=1 and go to IDLE.
- A job handshake in any state other than LOAD goes to LOAD. This aborts the current job: pending hits are cleared, FIFO contents and drop_cnt are kept.
- Check slot = a cycle with feedback_d1==0 in RUN or DRAIN. At each slot:
  - If warm>0: decrement warm and ignore the hashes.
  - Otherwise: hit[k] = (top `difficulty` bits of core_hash_top[k] are zero). OR the hit vector into pending, remember check_base for it, then check_base += NUM_CORES.
- Difficulty rules: 0 means every checked hash is golden; values >64 clamp to 64.
- Serializer pushes at most one pending hit per cycle, lowest core index first, as entry {check_base_of_slot + k, k}.
  - NUM_CORES ≤ LOOP guarantees pending is empty before the next slot.
- FIFO write when full: entry dropped, drop_cnt += 1, saturating at 255.
- Simultaneous push and pop on a full FIFO: both succeed, no drop.
- The pop happens when result_valid & result_ready. result_nonce and result_core are stable while result_valid=1 and result_ready=0.
- All nonce arithmetic is modulo 2^32.
- core_state and core_data stay at the latched job values until the next LOAD.

Test Plan:
1. Reset is held for 3 cycles → all outputs match the reset values above; cnt stays 0 while idle.
2. NUM_CORES=2, LOOP_LOG2=5, difficulty=0, start=0, result_ready=1 → core_nonce goes {0,1}, {2,3}, … every 32 cycles. Results come out in order 0,1,2,3,… with result_core alternating 0,1; the first result follows 5 warm-up check slots.
3. difficulty=32; the bench drives core_hash_top[1]=64'h00000000_0000FFFF only at the check slot for check_base=6, and all-ones otherwise → exactly one result: nonce 7, core 1.
4. difficulty=0, result_ready=0 → FIFO holds 4 entries (nonces 0..3); drop_cnt counts up and saturates at 255. Setting ready=1 then pops 0,1,2,3 in order.
5. start=32'hFFFFFFFC, difficulty=0 → issued passes are FFFFFFFC and FFFFFFFE, then DRAIN. Results are FFFFFFFC..FFFFFFFF, then busy=0 and exhausted=1. The next job clears exhausted.
6. A new job is accepted during RUN with 2 hits pending → those pending hits are discarded; FIFO entries already queued are kept; nonces restart at the new start value; warm-up repeats.

Source files
------------

// File: rtl/miner_nonce_ctrl.sv
// rtl/miner_nonce_ctrl.sv - multi-core nonce sequencer with runtime difficulty check and result FIFO
module miner_nonce_ctrl #(
  parameter int NUM_CORES   = 2,
  parameter int LOOP_LOG2   = 5,
  parameter int PIPE_PASSES = (1 << (7 - LOOP_LOG2)) + 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      hash_clk,
  input  logic                      reset,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [255:0]              job_midstate,
  input  logic [95:0]               job_data,
  input  logic [31:0]               job_nonce_start,
  input  logic [6:0]                job_difficulty,
  output logic [255:0]              core_state,
  output logic [95:0]               core_data,
  output logic [NUM_CORES*32-1:0]   core_nonce,
  output logic [5:0]                cnt,
  output logic                      feedback,
  input  logic [NUM_CORES*64-1:0]   core_hash_top,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [31:0]               result_nonce,
  output logic [7:0]                result_core,
  output logic                      busy,
  output logic                      exhausted,
  output logic [7:0]                drop_cnt
);

  localparam int          LOOP      = 1 << LOOP_LOG2;
  localparam int          CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NC        = 32'(NUM_CORES);
  localparam logic [5:0]  LOOP_MASK = 6'(LOOP - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [5:0]               cnt_q, cnt_d, cnt_next;
  logic                     fb_q, fb_d, fb_d1_q, fb_d1_d;
  logic [255:0]             midstate_q, midstate_d;
  logic [95:0]              data_q, data_d;
  logic [6:0]               diff_q, diff_d;
  logic [31:0]              base_q, base_d, check_base_q, check_base_d;
  logic [31:0]              pend_base_q, pend_base_d;
  logic [7:0]               warm_q, warm_d;
  logic [NUM_CORES-1:0]     pending_q, pending_d, hit, clr;
  logic [NUM_CORES*32-1:0]  nonce_q, nonce_d;
  logic                     exh_q, exh_d;
  logic [32:0]              base_sum;
  logic [63:0]              diff_mask;
  logic                     job_fire, active, slot, push;
  logic [CW-1:0]            sel;

  logic [31:0]              fifo_nonce_q [FIFO_DEPTH];
  logic [7:0]               fifo_core_q  [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [AW:0]              count_q;
  logic [7:0]               drop_q;
  logic                     pop, full, wr_en, drop;

  assign job_ready = (state_q != S_LOAD);
  assign job_fire  = job_valid & job_ready;
  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign cnt_next  = (cnt_q + 6'd1) & LOOP_MASK;
  assign slot      = active & ~fb_d1_q;
  assign base_sum  = {1'b0, base_q} + {1'b0, NC};
  // diff_q never exceeds 64; a shift of 64 yields zero, i.e. a full mask
  assign diff_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> diff_q);

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      hit[k] = ((core_hash_top[k*64 +: 64] & diff_mask) == 64'd0);
    end
  end

  // Serializer drains pending lowest core first; an accepted job suppresses it
  always_comb begin
    sel = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (pending_q[k]) sel = CW'(k);
    end
    push = (|pending_q) && (state_q != S_LOAD) && !job_fire;
    clr  = '0;
    if (push) clr[sel] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fb_d         = fb_q;
    fb_d1_d      = 1'b1;
    midstate_d   = midstate_q;
    data_d       = data_q;
    diff_d       = diff_q;
    base_d       = base_q;
    check_base_d = check_base_q;
    pend_base_d  = pend_base_q;
    warm_d       = warm_q;
    pending_d    = pending_q & ~clr;
    nonce_d      = nonce_q;
    exh_d        = exh_q;
    case (state_q)
      S_LOAD: begin
        midstate_d   = job_midstate;
        data_d       = job_data;
        diff_d       = (job_difficulty > 7'd64) ? 7'd64 : job_difficulty;
        base_d       = job_nonce_start & ~(NC - 32'd1);
        check_base_d = job_nonce_start & ~(NC - 32'd1);
        warm_d       = 8'(PIPE_PASSES);
        pending_d    = '0;
        exh_d        = 1'b0;
        state_d      = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        cnt_d   = cnt_next;
        fb_d    = (cnt_next != 6'd0);
        fb_d1_d = fb_q;
        if (state_q == S_RUN && cnt_next == 6'd0) begin
          for (int k = 0; k < NUM_CORES; k++) begin
            nonce_d[k*32 +: 32] = base_q + 32'(k);
          end
          base_d = base_sum[31:0];
          if (base_sum[32]) state_d = S_DRAIN;
        end
        if (slot) begin
          if (warm_q != 8'd0) begin
            warm_d = warm_q - 8'd1;
          end else begin
            pending_d    = pending_d | hit;
            pend_base_d  = check_base_q;
            check_base_d = check_base_q + NC;
            // base_q is frozen in DRAIN, so base_q-NC is the last issued pass
            if (state_q == S_DRAIN && check_base_q == base_q - NC) begin
              state_d = S_IDLE;
              exh_d   = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (job_fire) state_d = S_LOAD;
    if (state_d != S_RUN && state_d != S_DRAIN) begin
      cnt_d = 6'd0;
      fb_d  = 1'b0;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fb_q         <= 1'b0;
      fb_d1_q      <= 1'b1;
      midstate_q   <= '0;
      data_q       <= '0;
      diff_q       <= '0;
      base_q       <= '0;
      check_base_q <= '0;
      pend_base_q  <= '0;
      warm_q       <= '0;
      pending_q    <= '0;
      nonce_q      <= '0;
      exh_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fb_q         <= fb_d;
      fb_d1_q      <= fb_d1_d;
      midstate_q   <= midstate_d;
      data_q       <= data_d;
      diff_q       <= diff_d;
      base_q       <= base_d;
      check_base_q <= check_base_d;
      pend_base_q  <= pend_base_d;
      warm_q       <= warm_d;
      pending_q    <= pending_d;
      nonce_q      <= nonce_d;
      exh_q        <= exh_d;
    end
  end

  assign pop   = result_valid & result_ready;
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_nonce_q[i] <= '0;
        fifo_core_q[i]  <= '0;
      end
    end else begin
      if (wr_en) begin
        fifo_nonce_q[wr_ptr_q] <= pend_base_q + 32'(sel);
        fifo_core_q[wr_ptr_q]  <= 8'(sel);
        wr_ptr_q               <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign result_valid = (count_q != '0);
  assign result_nonce = fifo_nonce_q[rd_ptr_q];
  assign result_core  = fifo_core_q[rd_ptr_q];
  assign drop_cnt     = drop_q;
  assign cnt          = cnt_q;
  assign feedback     = fb_q;
  assign core_nonce   = nonce_q;
  assign core_state   = midstate_q;
  assign core_data    = data_q;
  assign busy         = active;
  assign exhausted    = exh_q;

endmodule

// File: tb/tb_miner_nonce_ctrl.sv
// tb/tb_miner_nonce_ctrl.sv - directed bench for miner_nonce_ctrl (2 cores, LOOP=32, 5 warm passes)
module tb_miner_nonce_ctrl;

  logic          hash_clk = 1'b0;
  logic          reset = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [255:0]  job_midstate = '0;
  logic [95:0]   job_data = '0;
  logic [31:0]   job_nonce_start = '0;
  logic [6:0]    job_difficulty = '0;
  logic [255:0]  core_state;
  logic [95:0]   core_data;
  logic [63:0]   core_nonce;
  logic [5:0]    cnt;
  logic          feedback;
  logic [127:0]  core_hash_top = '1;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [31:0]   result_nonce;
  logic [7:0]    result_core;
  logic          busy;
  logic          exhausted;
  logic [7:0]    drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int tcyc     = 0;
  int run0     = 0;

  miner_nonce_ctrl #(.NUM_CORES(2), .LOOP_LOG2(5), .FIFO_DEPTH(4)) dut (
    .hash_clk(hash_clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_data(job_data),
    .job_nonce_start(job_nonce_start), .job_difficulty(job_difficulty),
    .core_state(core_state), .core_data(core_data), .core_nonce(core_nonce),
    .cnt(cnt), .feedback(feedback), .core_hash_top(core_hash_top),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_nonce(result_nonce), .result_core(result_core),
    .busy(busy), .exhausted(exhausted), .drop_cnt(drop_cnt)
  );

  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) tcyc <= tcyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge hash_clk);
    reset = 1'b1;
    job_valid = 1'b0;
    result_ready = 1'b0;
    core_hash_top = '1;
    repeat (3) @(negedge hash_clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; handshake at the next posedge, returns at RUN cycle 0
  task automatic start_job(input logic [31:0] start, input logic [6:0] diff);
    chk("job_ready_pre", job_ready, 1);
    job_nonce_start = start;
    job_difficulty  = diff;
    job_valid       = 1'b1;
    @(negedge hash_clk);
    chk("job_ready_load", job_ready, 0);
    job_valid = 1'b0;
    @(negedge hash_clk);
    run0 = tcyc;
  endtask

  task automatic at_run(input int n);
    while (tcyc < run0 + n) @(negedge hash_clk);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] nonce, input logic [7:0] core);
    int n = 0;
    while (!result_valid && n < 400) begin
      @(negedge hash_clk);
      n++;
    end
    if (!result_valid) begin
      chk({tag, "_timeout"}, result_valid, 1);
    end else begin
      chk({tag, "_nonce"}, result_nonce, nonce);
      chk({tag, "_core"}, result_core, core);
      result_ready = 1'b1;
      @(negedge hash_clk);
      result_ready = 1'b0;
    end
  endtask

  initial begin
    job_midstate = {8{32'hA5C3_0F1E}};
    job_data     = 96'h1234_5678_9ABC_DEF0_0BAD_CAFE;

    // Test 1: reset values
    do_reset();
    chk("rst_cnt", cnt, 0);
    chk("rst_fb", feedback, 0);
    chk("rst_nonce", core_nonce, 0);
    chk("rst_state", core_state[63:0], 0);
    chk("rst_data", core_data[63:0], 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exh", exhausted, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ready", job_ready, 1);
    repeat (5) @(negedge hash_clk);
    chk("idle_cnt", cnt, 0);

    // Test 2: difficulty 0, nonce sequencing and in-order results
    start_job(32'd0, 7'd0);
    chk("t2_busy", busy, 1);
    chk("t2_fb0", feedback, 0);
    chk("t2_state", core_state[63:0], 64'hA5C3_0F1E_A5C3_0F1E);
    chk("t2_data", core_data[63:0], 64'h9ABC_DEF0_0BAD_CAFE);
    at_run(31);
    chk("t2_cnt31", cnt, 31);
    chk("t2_fb31", feedback, 1);
    at_run(32);
    chk("t2_nonce_p1", core_nonce, {32'd1, 32'd0});
    chk("t2_cnt32", cnt, 0);
    chk("t2_fb32", feedback, 0);
    at_run(64);
    chk("t2_nonce_p2", core_nonce, {32'd3, 32'd2});
    at_run(162);
    chk("t2_warm_empty", result_valid, 0);
    at_run(163);
    chk("t2_first_valid", result_valid, 1);
    for (int i = 0; i < 6; i++) pop_expect("t2_res", 32'(i), 8'(i % 2));

    // Test 3: difficulty 32, single planted hit plus 31/32-zero boundary
    do_reset();
    start_job(32'd0, 7'd32);
    at_run(257);
    core_hash_top[127:64] = 64'h0000_0000_0000_FFFF;
    at_run(258);
    core_hash_top = '1;
    pop_expect("t3_hit7", 32'd7, 8'd1);
    at_run(289);
    core_hash_top[63:0] = 64'h0000_0001_FFFF_FFFF;
    at_run(290);
    core_hash_top = '1;
    at_run(321);
    core_hash_top[63:0] = 64'h0000_0000_FFFF_FFFF;
    at_run(322);
    core_hash_top = '1;
    pop_expect("t3_hit10", 32'd10, 8'd0);
    at_run(400);
    chk("t3_no_more", result_valid, 0);

    // Test 4: FIFO full, drop counter saturation, push+pop while full
    do_reset();
    start_job(32'd0, 7'd0);
    at_run(230);
    chk("t4_drop2", drop_cnt, 2);
    chk("t4_head", result_nonce, 0);
    at_run(4266);
    chk("t4_drop254", drop_cnt, 254);
    at_run(4298);
    chk("t4_drop255", drop_cnt, 255);
    at_run(4330);
    chk("t4_drop_sat", drop_cnt, 255);
    at_run(4354);
    for (int i = 0; i < 4; i++) pop_expect("t4_keep", 32'(i), 8'(i % 2));
    pop_expect("t4_n262", 32'd262, 8'd0);
    pop_expect("t4_n263", 32'd263, 8'd1);

    // Test 5: end of nonce range, low start bit forced to zero
    do_reset();
    start_job(32'hFFFF_FFFD, 7'd0);
    at_run(32);
    chk("t5_nonce_p1", core_nonce, {32'hFFFF_FFFD, 32'hFFFF_FFFC});
    at_run(64);
    chk("t5_nonce_p2", core_nonce, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    chk("t5_busy_drain", busy, 1);
    at_run(96);
    chk("t5_frozen", core_nonce, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    pop_expect("t5_fc", 32'hFFFF_FFFC, 8'd0);
    pop_expect("t5_fd", 32'hFFFF_FFFD, 8'd1);
    at_run(193);
    chk("t5_busy_last", busy, 1);
    chk("t5_exh_pre", exhausted, 0);
    at_run(194);
    chk("t5_busy_done", busy, 0);
    chk("t5_exh", exhausted, 1);
    pop_expect("t5_fe", 32'hFFFF_FFFE, 8'd0);
    pop_expect("t5_ff", 32'hFFFF_FFFF, 8'd1);
    at_run(240);
    chk("t5_idle_cnt", cnt, 0);
    chk("t5_idle_empty", result_valid, 0);
    start_job(32'd0, 7'd0);
    chk("t5_exh_clr", exhausted, 0);

    // Test 6: abort with two hits pending
    do_reset();
    start_job(32'd0, 7'd0);
    at_run(226);
    chk("t6_full", result_valid, 1);
    chk("t6_drop_pre", drop_cnt, 0);
    start_job(32'h0000_0101, 7'd0);
    chk("t6_drop_abort", drop_cnt, 0);
    chk("t6_head_kept", result_nonce, 0);
    at_run(32);
    chk("t6_nonce_new", core_nonce, {32'h101, 32'h100});
    at_run(150);
    chk("t6_drop_warm", drop_cnt, 0);
    for (int i = 0; i < 4; i++) pop_expect("t6_keep", 32'(i), 8'(i % 2));
    at_run(162);
    chk("t6_rewarm", result_valid, 0);
    pop_expect("t6_n100", 32'h100, 8'd0);
    pop_expect("t6_n101", 32'h101, 8'd1);

    // Test 7: difficulty above 64 behaves as 64
    do_reset();
    core_hash_top = {64'd1, 64'd0};
    start_job(32'd0, 7'd100);
    pop_expect("t7_n0", 32'd0, 8'd0);
    pop_expect("t7_n2", 32'd2, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
